// File: rtl/game_pkg.sv
// Shared types and constants for the number-picking game and its scripted player.
// Latency: n/a (declarations and one combinational helper only).
// Backpressure: n/a.
package game_pkg;

    // Three distinct numbers from 1..9 summing to this value form a winning line.
    localparam int MAGIC_SUM = 15;
    localparam int NUM_MIN   = 1;
    localparam int NUM_MAX   = 9;

    typedef logic [3:0] move_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEWGAME,
        S_WAIT_TURN,
        S_PRESS,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } player_state_t;

    // Number of occupied move slots (a slot holding 0 is empty).
    function automatic logic [2:0] count_moves(input move_t m3, input move_t m2,
                                               input move_t m1, input move_t m0);
        count_moves = 3'(m3 != '0) + 3'(m2 != '0) + 3'(m1 != '0) + 3'(m0 != '0);
    endfunction

endpackage

// File: rtl/move_picker.sv
// Chooses the human's next number: win if possible, else block, else lowest free.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is valid whenever the inputs are.
//
// Ports:
//   h3..h0  : human moves recorded by the game (0 = empty slot)
//   c3..c0  : computer moves recorded by the game (0 = empty slot)
//   pick    : chosen number 1..9 (0 when nothing is free)
//   valid   : a free number exists
module move_picker
    import game_pkg::*;
(
    input  move_t       h3,
    input  move_t       h2,
    input  move_t       h1,
    input  move_t       h0,
    input  move_t       c3,
    input  move_t       c2,
    input  move_t       c1,
    input  move_t       c0,
    output logic [3:0]  pick,
    output logic        valid
);

    move_t hm [4];
    move_t cm [4];

    assign hm[0] = h0;
    assign hm[1] = h1;
    assign hm[2] = h2;
    assign hm[3] = h3;
    assign cm[0] = c0;
    assign cm[1] = c1;
    assign cm[2] = c2;
    assign cm[3] = c3;

    // Bit n of each mask refers to the number n.
    logic [NUM_MAX:NUM_MIN] free_mask;
    logic [NUM_MAX:NUM_MIN] win_mask;
    logic [NUM_MAX:NUM_MIN] blk_mask;

    // True when n together with two occupied slots a and b sums to the magic value.
    // Five bits keep the sum from wrapping (9 + 9 + 9 < 32).
    function automatic logic completes(input move_t a, input move_t b, input int n);
        completes = (a != '0) && (b != '0) &&
                    ((5'(n) + 5'(a) + 5'(b)) == 5'(MAGIC_SUM));
    endfunction

    // Returns {found, number} for the lowest set bit of m.
    function automatic logic [4:0] lowest(input logic [NUM_MAX:NUM_MIN] m);
        lowest = '0;
        for (int n = NUM_MAX; n >= NUM_MIN; n--) begin
            if (m[n]) begin
                lowest = {1'b1, 4'(n)};
            end
        end
    endfunction

    always_comb begin
        free_mask = '1;
        win_mask  = '0;
        blk_mask  = '0;
        for (int n = NUM_MIN; n <= NUM_MAX; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (hm[i] == 4'(n) || cm[i] == 4'(n)) begin
                    free_mask[n] = 1'b0;
                end
            end
            // Slot pairs are distinct by index; i < j avoids pairing a slot with itself.
            for (int i = 0; i < 4; i++) begin
                for (int j = i + 1; j < 4; j++) begin
                    if (completes(hm[i], hm[j], n)) begin
                        win_mask[n] = 1'b1;
                    end
                    if (completes(cm[i], cm[j], n)) begin
                        blk_mask[n] = 1'b1;
                    end
                end
            end
        end
    end

    logic [4:0] win_sel;
    logic [4:0] blk_sel;
    logic [4:0] any_sel;

    assign win_sel = lowest(win_mask & free_mask);
    assign blk_sel = lowest(blk_mask & free_mask);
    assign any_sel = lowest(free_mask);

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        if (win_sel[4]) begin
            pick  = win_sel[3:0];
            valid = 1'b1;
        end else if (blk_sel[4]) begin
            pick  = blk_sel[3:0];
            valid = 1'b1;
        end else if (any_sel[4]) begin
            pick  = any_sel[3:0];
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/auto_human_player.sv
// Scripted human opponent: reads the game's move registers and works enter/new-game.
// Latency: press starts 1 cycle after the turn is seen; each press lasts PRESS_CYCLES.
// Backpressure: waits on the game (turn / recorded move) up to TIMEOUT cycles, then errors.
//
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   start               : begin a new game (honoured only in IDLE, DONE, ERROR)
//   h3..h0, c3..c0      : game's recorded human / computer moves (0 = empty)
//   cMove               : game's latest computer move (observed only)
//   win                 : game-over indication from the game
//   hMove               : number presented to the game, changes only on entering a press
//   enter_L, newGame_L  : active-low buttons
//   movesMade           : human moves the game has accepted this game (0..4)
//   done, error         : normal finish / timeout or no legal move
module auto_human_player
    import game_pkg::*;
#(
    parameter int PRESS_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  move_t       h3,
    input  move_t       h2,
    input  move_t       h1,
    input  move_t       h0,
    input  move_t       c3,
    input  move_t       c2,
    input  move_t       c1,
    input  move_t       c0,
    input  move_t       cMove,
    input  logic        win,
    output logic [3:0]  hMove,
    output logic        enter_L,
    output logic        newGame_L,
    output logic [2:0]  movesMade,
    output logic        done,
    output logic        error
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = (PRESS_CYCLES > 1) ? $clog2(PRESS_CYCLES) : 1;

    player_state_t state;
    player_state_t state_next;

    logic [TW-1:0] tcnt;
    logic [PW-1:0] pcnt;
    logic [2:0]    h_cnt;
    logic [2:0]    c_cnt;
    logic [2:0]    h_cnt_lat;
    logic          win_seen;

    logic [3:0]    pick;
    logic          pick_vld;

    // cMove is kept on the interface for observation; decisions use the slots only.
    logic          unused_cmove;
    assign unused_cmove = ^cMove;

    move_picker u_picker (
        .h3    (h3),
        .h2    (h2),
        .h1    (h1),
        .h0    (h0),
        .c3    (c3),
        .c2    (c2),
        .c1    (c1),
        .c0    (c0),
        .pick  (pick),
        .valid (pick_vld)
    );

    assign h_cnt = count_moves(h3, h2, h1, h0);
    assign c_cnt = count_moves(c3, c2, c1, c0);

    logic board_full;
    logic my_turn;
    logic timed_out;
    logic press_last;
    logic h_adv;
    logic game_over;

    assign board_full = (4'(h_cnt) + 4'(c_cnt)) == 4'd9;
    assign my_turn    = (c_cnt > h_cnt) && !win;
    // The counter reads 0 on the first cycle of a state, so TIMEOUT-1 means the
    // state has now waited TIMEOUT cycles; error lands on the following edge.
    assign timed_out  = tcnt >= TW'(TIMEOUT - 1);
    assign press_last = pcnt >= PW'(PRESS_CYCLES - 1);
    assign h_adv      = h_cnt > h_cnt_lat;
    // A win that arrives mid-press is remembered so the press can complete first.
    assign game_over  = win || win_seen;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_NEWGAME;
            end
            S_NEWGAME: begin
                if (press_last) state_next = S_WAIT_TURN;
            end
            S_WAIT_TURN: begin
                if (win) begin
                    state_next = S_DONE;
                end else if (board_full || h_cnt == 3'd4) begin
                    state_next = S_DONE;
                end else if (my_turn) begin
                    state_next = pick_vld ? S_PRESS : S_ERROR;
                end else if (timed_out) begin
                    state_next = S_ERROR;
                end
            end
            S_PRESS: begin
                if (press_last) state_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (game_over) begin
                    state_next = S_DONE;
                end else if (h_adv) begin
                    state_next = S_WAIT_TURN;
                end else if (timed_out) begin
                    state_next = S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) state_next = S_NEWGAME;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            pcnt      <= '0;
            h_cnt_lat <= '0;
            win_seen  <= 1'b0;
            hMove     <= '0;
            enter_L   <= 1'b1;
            newGame_L <= 1'b1;
            movesMade <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state <= state_next;

            // Both counters measure time spent in the current state.
            if (state_next != state) begin
                tcnt <= '0;
                pcnt <= '0;
            end else begin
                if (tcnt != TW'(TIMEOUT)) tcnt <= tcnt + 1'b1;
                if (!press_last)          pcnt <= pcnt + 1'b1;
            end

            // Move and baseline count are captured together on the way into PRESS.
            if (state == S_WAIT_TURN && state_next == S_PRESS) begin
                hMove     <= pick;
                h_cnt_lat <= h_cnt;
            end

            if (state_next == S_PRESS && state != S_PRESS) begin
                win_seen <= 1'b0;
            end else if ((state == S_PRESS || state == S_RELEASE) && win) begin
                win_seen <= 1'b1;
            end

            if (state_next == S_NEWGAME) begin
                movesMade <= '0;
            end else if (state == S_RELEASE && h_adv) begin
                movesMade <= movesMade + 1'b1;
            end

            // Outputs follow the next state so they change on the same edge as it.
            enter_L   <= (state_next != S_PRESS);
            newGame_L <= (state_next != S_NEWGAME);
            done      <= (state_next == S_DONE);
            error     <= (state_next == S_ERROR);
        end
    end

endmodule

// File: tb/tb_auto_human_player.sv
module tb_auto_human_player;

    localparam int PC = 2;
    localparam int TO = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        win   = 1'b0;
    logic [3:0]  h3 = '0, h2 = '0, h1 = '0, h0 = '0;
    logic [3:0]  c3 = '0, c2 = '0, c1 = '0, c0 = '0;
    logic [3:0]  cMove = '0;
    logic [3:0]  hMove;
    logic        enter_L;
    logic        newGame_L;
    logic [2:0]  movesMade;
    logic        done;
    logic        error;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    auto_human_player #(.PRESS_CYCLES(PC), .TIMEOUT(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .h3        (h3),
        .h2        (h2),
        .h1        (h1),
        .h0        (h0),
        .c3        (c3),
        .c2        (c2),
        .c1        (c1),
        .c0        (c0),
        .cMove     (cMove),
        .win       (win),
        .hMove     (hMove),
        .enter_L   (enter_L),
        .newGame_L (newGame_L),
        .movesMade (movesMade),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] h;        // {h3,h2,h1,h0}
        logic [15:0] c;        // {c3,c2,c1,c0}
        logic [3:0]  exp_move;
    } vec_t;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] add_move(input logic [15:0] hb, input logic [3:0] m);
        logic [15:0] r;
        bit placed;
        r = hb;
        placed = 0;
        for (int i = 0; i < 4; i++) begin
            if (!placed && r[i*4 +: 4] == 4'd0) begin
                r[i*4 +: 4] = m;
                placed = 1;
            end
        end
        return r;
    endfunction

    task automatic start_game(input logic [15:0] hb, input logic [15:0] cb, input string tag);
        int n;
        win   = 1'b0;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        {h3, h2, h1, h0} = hb;
        {c3, c2, c1, c0} = cb;
        start = 1'b1;
        tick;
        start = 1'b0;
        check({tag, "_newgame_low"}, 32'(newGame_L), 32'd0);
        n = 0;
        while (newGame_L == 1'b0 && n < 20) begin
            n++;
            tick;
        end
        check({tag, "_newgame_len"}, 32'(n), 32'(PC));
    endtask

    // Waits (bounded) for enter_L to fall, then checks hMove across the whole press.
    task automatic do_press(input logic [3:0] exp_m, input string tag, output int waited);
        int n;
        waited = 0;
        while (enter_L !== 1'b0 && waited < TO + 8) begin
            tick;
            waited++;
        end
        check({tag, "_enter_low"}, 32'(enter_L), 32'd0);
        n = 0;
        while (enter_L == 1'b0 && n < 20) begin
            check({tag, "_hmove"}, 32'(hMove), 32'(exp_m));
            n++;
            tick;
        end
        check({tag, "_enter_len"}, 32'(n), 32'(PC));
    endtask

    task automatic wait_moves(input logic [2:0] exp_mm, input string tag);
        int n;
        n = 0;
        while (movesMade !== exp_mm && n < 10) begin
            tick;
            n++;
        end
        check({tag, "_moves_made"}, 32'(movesMade), 32'(exp_mm));
    endtask

    vec_t vecs [9];

    initial begin
        int waited;
        int n;

        vecs[0] = '{h: 16'h0000, c: 16'h0005, exp_move: 4'd1}; // lowest free
        vecs[1] = '{h: 16'h0006, c: 16'h0015, exp_move: 4'd9}; // block 1+5
        vecs[2] = '{h: 16'h0042, c: 16'h0513, exp_move: 4'd9}; // win 9 beats block 7
        vecs[3] = '{h: 16'h0000, c: 16'h1000, exp_move: 4'd2}; // c3 slot, lowest free
        vecs[4] = '{h: 16'h0100, c: 16'h2030, exp_move: 4'd4}; // no line reachable
        vecs[5] = '{h: 16'h0002, c: 16'h0043, exp_move: 4'd8}; // block 4+3 over free 1
        vecs[6] = '{h: 16'h1630, c: 16'h2579, exp_move: 4'd8}; // win 8 beats block 4
        vecs[7] = '{h: 16'h1590, c: 16'h2346, exp_move: 4'd7}; // lowest of two blocks
        vecs[8] = '{h: 16'h0089, c: 16'h0123, exp_move: 4'd4}; // h pair too large to win

        // Reset state
        tick;
        tick;
        reset = 1'b0;
        check("rst_hmove",     32'(hMove),     32'd0);
        check("rst_enter",     32'(enter_L),   32'd1);
        check("rst_newgame",   32'(newGame_L), 32'd1);
        check("rst_moves",     32'(movesMade), 32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_error",     32'(error),     32'd0);

        // Table: one press per vector, then the game records it.
        for (int v = 0; v < 9; v++) begin
            start_game(vecs[v].h, vecs[v].c, $sformatf("vec%0d", v));
            do_press(vecs[v].exp_move, $sformatf("vec%0d", v), waited);
            check($sformatf("vec%0d_press_delay", v), 32'(waited), 32'd1);
            check($sformatf("vec%0d_moves_before", v), 32'(movesMade), 32'd0);
            {h3, h2, h1, h0} = add_move(vecs[v].h, vecs[v].exp_move);
            wait_moves(3'd1, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_error", v), 32'(error), 32'd0);
        end

        // Two moves in one game: movesMade goes 1 -> 2.
        start_game(16'h0000, 16'h0005, "seq2");
        do_press(4'd1, "seq2_m1", waited);
        {h3, h2, h1, h0} = 16'h0001;
        wait_moves(3'd1, "seq2_m1");
        {h3, h2, h1, h0} = 16'h0006;
        {c3, c2, c1, c0} = 16'h0015;
        do_press(4'd9, "seq2_m2", waited);
        check("seq2_moves_mid", 32'(movesMade), 32'd1);
        {h3, h2, h1, h0} = 16'h0096;
        wait_moves(3'd2, "seq2_m2");

        // Reset in the middle of a press.
        start_game(16'h0000, 16'h0005, "rstp");
        waited = 0;
        while (enter_L !== 1'b0 && waited < 10) begin
            tick;
            waited++;
        end
        check("rstp_in_press", 32'(enter_L), 32'd0);
        reset = 1'b1;
        tick;
        check("rstp_enter",   32'(enter_L),   32'd1);
        check("rstp_newgame", 32'(newGame_L), 32'd1);
        check("rstp_hmove",   32'(hMove),     32'd0);
        reset = 1'b0;
        tick;
        tick;
        tick;
        check("rstp_idle_enter",   32'(enter_L),   32'd1);
        check("rstp_idle_newgame", 32'(newGame_L), 32'd1);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("rstp_restart", 32'(newGame_L), 32'd0);

        // Game never records the move: error exactly TO cycles after release.
        start_game(16'h0000, 16'h0005, "tmo");
        do_press(4'd1, "tmo", waited);
        for (int i = 0; i < TO - 1; i++) tick;
        check("tmo_error_early", 32'(error), 32'd0);
        tick;
        check("tmo_error",       32'(error),   32'd1);
        check("tmo_enter",       32'(enter_L), 32'd1);
        check("tmo_done",        32'(done),    32'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("tmo_error_clr",   32'(error),     32'd0);
        check("tmo_restart",     32'(newGame_L), 32'd0);

        // win while waiting for a turn.
        start_game(16'h0000, 16'h0000, "winw");
        tick;
        check("winw_done_before", 32'(done), 32'd0);
        win = 1'b1;
        tick;
        check("winw_done", 32'(done), 32'd1);
        {c3, c2, c1, c0} = 16'h0005;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (enter_L == 1'b0) n++;
        end
        win = 1'b0;
        tick;
        tick;
        check("winw_no_press", 32'(n),    32'd0);
        check("winw_held",     32'(done), 32'd1);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("winw_done_clr", 32'(done),      32'd0);
        check("winw_restart",  32'(newGame_L), 32'd0);

        // Four human moves already on the board ends the game.
        start_game(16'h1234, 16'h5678, "full");
        tick;
        check("full_done",  32'(done),    32'd1);
        check("full_enter", 32'(enter_L), 32'd1);

        // win rising mid-press: the press completes, then done.
        start_game(16'h0000, 16'h0005, "winp");
        waited = 0;
        while (enter_L !== 1'b0 && waited < 10) begin
            tick;
            waited++;
        end
        win = 1'b1;
        n = 0;
        while (enter_L == 1'b0 && n < 20) begin
            n++;
            tick;
        end
        check("winp_press_len", 32'(n), 32'(PC));
        n = 0;
        while (done !== 1'b1 && n < 5) begin
            tick;
            n++;
        end
        check("winp_done",  32'(done),      32'd1);
        check("winp_moves", 32'(movesMade), 32'd0);
        check("winp_err",   32'(error),     32'd0);
        win = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
